sram_mem_controller: RTL and testbench

- Sequences the MEM-stage data accesses that the decode stage marks as LDR (read) or STR (write) onto an external 16-bit asynchronous SRAM.
- Splits each 32-bit word access into two 16-bit half accesses, low half first.
- Holds the pipeline through a ready/stall handshake, lowering ready for the whole access.
- Sits between the MEM stage and the board SRAM pins.

---
 rtl/sram_mem_controller.sv | 146 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//
// Purpose:
//   Connects the MEM-stage loads (LDR) and stores (STR) to an external 16-bit
//   asynchronous SRAM. Each 32-bit word access is split into two 16-bit
//   halves, and the low half is accessed first. The pipeline is stalled by
//   holding ready low for the whole access.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   MEM_R_EN     load request, held until ready=1
//   MEM_W_EN     store request, held until ready=1
//   address      byte address from the ALU
//   writeData    store data
//   readData     load result, valid from the DONE cycle onward
//   ready        0 = stall the pipeline
//   SRAM_ADDR    SRAM half-word address
//   SRAM_DQ_OUT  write data driven to the pad
//   SRAM_DQ_IN   read data from the pad
//   SRAM_DQ_OE   1 = pad drives SRAM_DQ_OUT
//   SRAM_WE_N    active-low write strobe
// ---------------------------------------------------------------------------
module sram_mem_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        address,
    input  logic [31:0]        writeData,
    output logic [31:0]        readData,
    output logic               ready,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic [15:0]        SRAM_DQ_OUT,
    input  logic [15:0]        SRAM_DQ_IN,
    output logic               SRAM_DQ_OE,
    output logic               SRAM_WE_N
);

    localparam int CW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      counter;
    logic               op_rd;
    logic [SRAM_AW-2:0] word_q;
    logic [31:0]        wdata_q;

    logic               req;
    logic [SRAM_AW-2:0] word_in;
    logic [CW-1:0]      counter_nxt;

    assign req         = MEM_R_EN | MEM_W_EN;
    // Map the byte address to a word index. Any high bits beyond the SRAM
    // range are dropped, so no range check is done.
    assign word_in     = (SRAM_AW-1)'((address - 32'(BASE_ADDR)) >> 2);
    assign counter_nxt = counter + CW'(1);

    assign ready = ((state == IDLE) && !req) || (state == DONE);

    // Single FSM with registered pad outputs. The strobe for the next cycle
    // is decided one edge early. As a result, WE_N goes high exactly on the
    // final cycle of a write half, and that rising edge commits the data
    // while the address is still stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            op_rd       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= '0;
            readData    <= '0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_OUT <= '0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        // If both enables are set, the access is treated as a read.
                        op_rd     <= MEM_R_EN;
                        word_q    <= word_in;
                        wdata_q   <= writeData;
                        counter   <= '0;
                        state     <= LO;
                        SRAM_ADDR <= {word_in, 1'b0};
                        if (!MEM_R_EN) begin
                            SRAM_DQ_OE  <= 1'b1;
                            SRAM_DQ_OUT <= writeData[15:0];
                            SRAM_WE_N   <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (counter == LAST) begin
                        if (op_rd) begin
                            readData[15:0] <= SRAM_DQ_IN;
                        end else begin
                            SRAM_DQ_OUT <= wdata_q[31:16];
                            SRAM_WE_N   <= 1'b0;
                        end
                        counter   <= '0;
                        state     <= HI;
                        SRAM_ADDR <= {word_q, 1'b1};
                    end else begin
                        counter <= counter_nxt;
                        if (!op_rd) begin
                            SRAM_WE_N <= (counter_nxt == LAST);
                        end
                    end
                end
                HI: begin
                    if (counter == LAST) begin
                        if (op_rd) begin
                            readData[31:16] <= SRAM_DQ_IN;
                        end
                        counter    <= '0;
                        state      <= DONE;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_DQ_OE <= 1'b0;
                    end else begin
                        counter <= counter_nxt;
                        if (!op_rd) begin
                            SRAM_WE_N <= (counter_nxt == LAST);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Purpose:
//   Self-checking bench for sram_mem_controller. It includes a behavioural
//   asynchronous SRAM that commits writes on the rising edge of WE_N.
//   Load results are kept in a queue when a load is driven, then popped and
//   compared in the DONE cycle. A second instance uses WAIT_CYCLES=3.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;

    logic        clk;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_OUT;
    logic [15:0] SRAM_DQ_IN;
    logic        SRAM_DQ_OE;
    logic        SRAM_WE_N;

    logic        w3_r_en;
    logic        w3_w_en;
    logic [31:0] w3_address;
    logic [31:0] w3_wdata;
    logic [31:0] w3_rdata;
    logic        w3_ready;
    logic [17:0] w3_sram_addr;
    logic [15:0] w3_dq_out;
    logic        w3_dq_oe;
    logic        w3_we_n;

    logic [15:0] sram [0:(1<<18)-1];
    logic [31:0] exp_q [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int we_low   = 0;
    int w3_low   = 0;

    sram_mem_controller dut (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (MEM_R_EN),
        .MEM_W_EN   (MEM_W_EN),
        .address    (address),
        .writeData  (writeData),
        .readData   (readData),
        .ready      (ready),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_DQ_OUT(SRAM_DQ_OUT),
        .SRAM_DQ_IN (SRAM_DQ_IN),
        .SRAM_DQ_OE (SRAM_DQ_OE),
        .SRAM_WE_N  (SRAM_WE_N)
    );

    sram_mem_controller #(.WAIT_CYCLES(3)) dut_w3 (
        .clk        (clk),
        .rst        (rst),
        .MEM_R_EN   (w3_r_en),
        .MEM_W_EN   (w3_w_en),
        .address    (w3_address),
        .writeData  (w3_wdata),
        .readData   (w3_rdata),
        .ready      (w3_ready),
        .SRAM_ADDR  (w3_sram_addr),
        .SRAM_DQ_OUT(w3_dq_out),
        .SRAM_DQ_IN (16'h0000),
        .SRAM_DQ_OE (w3_dq_oe),
        .SRAM_WE_N  (w3_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count the cycles in which each strobe is low. These are sampled mid-cycle.
    always @(negedge clk) begin
        if (SRAM_WE_N == 1'b0) we_low <= we_low + 1;
        if (w3_we_n == 1'b0) w3_low <= w3_low + 1;
    end

    // Asynchronous SRAM model. Reads are combinational, and a write commits
    // on the rising edge of the strobe.
    assign SRAM_DQ_IN = sram[SRAM_ADDR];
    always @(posedge SRAM_WE_N) begin
        if (SRAM_DQ_OE) sram[SRAM_ADDR] = SRAM_DQ_OUT;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Drive one access at a negedge while the FSM is in IDLE. Then count the
    // stalled cycles up to DONE and compare any load result. The enables stay
    // asserted if hold is set, so back-to-back traffic can be issued. The
    // task returns at the negedge of the following cycle.
    task automatic apply_stimulus(input logic rd, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] exp_rd, input logic hold,
                                  output int low, output int strobes);
        int n;
        int we_start;
        logic [31:0] exp;
        n = 0;
        if (rd) exp_q.push_back(exp_rd);
        MEM_R_EN  = rd;
        MEM_W_EN  = wr;
        address   = addr;
        writeData = wdata;
        #1;
        we_start = we_low;
        while (!ready && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (!ready) check_output("ready_timeout", 32'(ready), 32'd1);
        if (rd && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_output("read_data", readData, exp);
        end
        low     = n;
        strobes = we_low - we_start;
        if (!hold) begin
            MEM_R_EN = 1'b0;
            MEM_W_EN = 1'b0;
        end
        @(negedge clk);
    endtask

    initial begin
        int low;
        int strobes;
        int c0;
        int n;
        int w3_start;

        rst        = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        address    = 32'd0;
        writeData  = 32'd0;
        w3_r_en    = 1'b0;
        w3_w_en    = 1'b0;
        w3_address = 32'd0;
        w3_wdata   = 32'd0;

        repeat (2) @(negedge clk);
        check_output("rst_readData", readData, 32'd0);
        check_output("rst_we_n", 32'(SRAM_WE_N), 32'd1);
        check_output("rst_oe", 32'(SRAM_DQ_OE), 32'd0);
        check_output("rst_addr", 32'(SRAM_ADDR), 32'd0);
        check_output("rst_ready", 32'(ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Reset during the low half of a store.
        MEM_W_EN  = 1'b1;
        address   = 32'd1024;
        writeData = 32'h55AA_1234;
        @(negedge clk);
        check_output("lo_we_n", 32'(SRAM_WE_N), 32'd0);
        check_output("lo_oe", 32'(SRAM_DQ_OE), 32'd1);
        check_output("lo_dq_out", 32'(SRAM_DQ_OUT), 32'h1234);
        rst = 1'b1;
        #1;
        check_output("midrst_we_n", 32'(SRAM_WE_N), 32'd1);
        check_output("midrst_oe", 32'(SRAM_DQ_OE), 32'd0);
        MEM_W_EN = 1'b0;
        #1;
        check_output("midrst_ready", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        sram[0] = 16'h1234;
        sram[1] = 16'hABCD;
        sram[2] = 16'h5678;
        sram[3] = 16'h9ABC;

        // Store, then load, at 1032 (SRAM half-words 4 and 5).
        apply_stimulus(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0, 1'b0, low, strobes);
        check_output("store_stall", 32'(low), 32'd5);
        check_output("store_strobes", 32'(strobes), 32'd2);
        check_output("sram4", 32'(sram[4]), 32'h0000BEEF);
        check_output("sram5", 32'(sram[5]), 32'h0000DEAD);
        apply_stimulus(1'b1, 1'b0, 32'd1032, 32'd0, 32'hDEADBEEF, 1'b0, low, strobes);
        check_output("load_stall", 32'(low), 32'd5);
        check_output("load_strobes", 32'(strobes), 32'd0);

        // Idle passthrough.
        for (int i = 0; i < 10; i++) begin
            #1;
            check_output("idle_ready", 32'(ready), 32'd1);
            check_output("idle_we_n", 32'(SRAM_WE_N), 32'd1);
            check_output("idle_readData", readData, 32'hDEADBEEF);
            @(negedge clk);
        end

        // Both enables set: the access behaves as a read and no strobe is issued.
        apply_stimulus(1'b1, 1'b1, 32'd1024, 32'hFFFF_FFFF, 32'hABCD_1234, 1'b0, low, strobes);
        check_output("both_stall", 32'(low), 32'd5);
        check_output("both_strobes", 32'(strobes), 32'd0);
        check_output("both_sram0", 32'(sram[0]), 32'h1234);

        // Back-to-back loads with the request held across DONE.
        c0 = cyc;
        apply_stimulus(1'b1, 1'b0, 32'd1024, 32'd0, 32'hABCD_1234, 1'b1, low, strobes);
        check_output("b2b_stall0", 32'(low), 32'd5);
        apply_stimulus(1'b1, 1'b0, 32'd1028, 32'd0, 32'h9ABC_5678, 1'b0, low, strobes);
        check_output("b2b_stall1", 32'(low), 32'd5);
        check_output("b2b_total", 32'(cyc - c0), 32'd12);

        // Store with WAIT_CYCLES=3.
        w3_w_en    = 1'b1;
        w3_address = 32'd1024;
        w3_wdata   = 32'hCAFE_F00D;
        #1;
        w3_start = w3_low;
        n = 0;
        while (!w3_ready && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        check_output("w3_stall", 32'(n), 32'd7);
        check_output("w3_strobes", 32'(w3_low - w3_start), 32'd4);
        w3_w_en = 1'b0;
        @(negedge clk);
        #1;
        check_output("w3_idle_ready", 32'(w3_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
